udma_eth_frame_rx_buf: RTL and testbench

// Store-and-forward RX frame buffer between the eth RX DC FIFO (sys_clk side) and the uDMA RX channel.

---
 rtl/udma_eth_frame_rx_buf.sv | 163 ++++++++++++++++
 tb/tb_udma_eth_frame_rx_buf.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/udma_eth_frame_rx_buf.sv
// udma_eth_frame_rx_buf: store-and-forward RX frame buffer feeding the uDMA RX channel.
// Drops errored or oversized frames; forwards good ones packed into 8/16/32-bit beats.
module udma_eth_frame_rx_buf #(
   parameter int  DEPTH          = 2048,
   parameter int  LEN_FIFO_DEPTH = 4,
   parameter int  DROP_CNT_W     = 16,
   localparam int AW             = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clr_i,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   input  logic [1:0]            cfg_datasize_i,
   output logic [31:0]           data_o,
   output logic                  data_valid_o,
   input  logic                  data_ready_i,
   output logic [1:0]            data_datasize_o,
   output logic                  data_last_o,
   output logic [AW:0]           frame_len_o,
   output logic                  frame_busy_o,
   output logic                  drop_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
);
   localparam int LW = $clog2(LEN_FIFO_DEPTH);
   localparam logic [1:0] W_IDLE = 2'd0, W_RECV = 2'd1, W_DISC = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0, R_READ = 1'b1;

   logic [7:0]            mem_q [DEPTH];
   logic [AW:0]           lf_q [LEN_FIFO_DEPTH];
   logic [AW:0]           wr_q, wr_d, commit_q, commit_d, rd_q, rd_d, cnt_q, cnt_d;
   logic [AW:0]           rem_q, rem_d, len_q, len_d, blen, nmax, take;
   logic [LW:0]           lwp_q, lrp_q;
   logic [1:0]            ws_q, ws_d, dsz_q, dsz_d, sz;
   logic [0:0]            rs_q, rs_d;
   logic                  silent_q, silent_d, valid_q, valid_d, last_q, last_d, drop_q, drop_d;
   logic [DROP_CNT_W-1:0] dcnt_q, dcnt_d;
   logic [31:0]           data_q;
   logic                  full, lf_full, lf_empty, acc, wen, bad, push, mid, start, step, load;

   assign full          = (wr_q - rd_q) == (AW+1)'(DEPTH);
   assign lf_full       = (lwp_q - lrp_q) == (LW+1)'(LEN_FIFO_DEPTH);
   assign lf_empty      = lwp_q == lrp_q;
   assign s_axis_tready = !(ws_q == W_IDLE && lf_full);
   assign acc           = s_axis_tvalid && s_axis_tready;
   assign wen           = acc && ws_q != W_DISC && !full;
   assign bad           = s_axis_tuser || ws_q == W_DISC || full;
   assign push          = acc && s_axis_tlast && !bad;
   // a flush mid-frame must swallow the remainder of that frame without counting it
   assign mid           = acc ? !s_axis_tlast : ws_q != W_IDLE;

   always_comb begin
      wr_d     = wr_q;
      commit_d = commit_q;
      cnt_d    = cnt_q;
      ws_d     = ws_q;
      silent_d = silent_q;
      drop_d   = 1'b0;
      dcnt_d   = dcnt_q;
      if (acc) begin
         if (wen) begin
            wr_d  = wr_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
         end
         if (s_axis_tlast) begin
            ws_d     = W_IDLE;
            cnt_d    = '0;
            silent_d = 1'b0;
            if (bad) begin
               wr_d   = commit_q;
               drop_d = !(ws_q == W_DISC && silent_q);
               dcnt_d = (drop_d && !(&dcnt_q)) ? dcnt_q + 1'b1 : dcnt_q;
            end else begin
               commit_d = wr_q + 1'b1;
            end
         end else begin
            ws_d = (ws_q == W_DISC || full) ? W_DISC : W_RECV;
         end
      end
   end

   // a new frame may be popped in the same cycle the previous last beat is taken
   assign start = !lf_empty && (rs_q == R_IDLE || (valid_q && data_ready_i && last_q));
   assign step  = valid_q && data_ready_i && !last_q;
   assign load  = start || step;
   assign sz    = start ? (cfg_datasize_i == 2'b11 ? 2'b10 : cfg_datasize_i) : dsz_q;
   assign blen  = start ? lf_q[lrp_q[LW-1:0]] : rem_q;
   assign nmax  = (AW+1)'(3'd1 << sz);
   assign take  = blen < nmax ? blen : nmax;

   always_comb begin
      rd_d    = load ? rd_q + take : rd_q;
      rem_d   = load ? blen - take : rem_q;
      len_d   = start ? blen : len_q;
      dsz_d   = start ? sz : dsz_q;
      last_d  = load ? blen == take : last_q;
      valid_d = load ? 1'b1 : (valid_q && data_ready_i) ? 1'b0 : valid_q;
      rs_d    = load ? R_READ : (valid_q && data_ready_i) ? R_IDLE : rs_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i || clr_i) begin
         ws_q     <= (rstn_i && mid) ? W_DISC : W_IDLE;
         silent_q <= rstn_i && mid;
         wr_q     <= '0;
         commit_q <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         lwp_q    <= '0;
         lrp_q    <= '0;
         rs_q     <= R_IDLE;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         dsz_q    <= '0;
         len_q    <= '0;
         rem_q    <= '0;
         drop_q   <= 1'b0;
         dcnt_q   <= '0;
      end else begin
         ws_q     <= ws_d;
         silent_q <= silent_d;
         wr_q     <= wr_d;
         commit_q <= commit_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         lwp_q    <= push ? lwp_q + 1'b1 : lwp_q;
         lrp_q    <= start ? lrp_q + 1'b1 : lrp_q;
         rs_q     <= rs_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         dsz_q    <= dsz_d;
         len_q    <= len_d;
         rem_q    <= rem_d;
         drop_q   <= drop_d;
         dcnt_q   <= dcnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wen) mem_q[wr_q[AW-1:0]] <= s_axis_tdata;
      if (push) lf_q[lwp_q[LW-1:0]] <= cnt_q + 1'b1;
   end

   // synchronous read straight into the beat register; bytes past the frame end read as zero
   always_ff @(posedge clk_i) begin
      if (!rstn_i || clr_i) data_q <= '0;
      else if (load)
         for (int k = 0; k < 4; k++)
            data_q[8*k +: 8] <= ((AW+1)'(k) < take) ? mem_q[AW'(rd_q + (AW+1)'(k))] : 8'h00;
   end

   assign data_o          = data_q;
   assign data_valid_o    = valid_q;
   assign data_datasize_o = dsz_q;
   assign data_last_o     = last_q;
   assign frame_len_o     = len_q;
   assign frame_busy_o    = rs_q == R_READ;
   assign drop_o          = drop_q;
   assign drop_cnt_o      = dcnt_q;
endmodule

// File: tb/tb_udma_eth_frame_rx_buf.sv
// tb_udma_eth_frame_rx_buf: random and directed frames against a queue-of-beats reference model.
module tb_udma_eth_frame_rx_buf;
   localparam int DEPTH = 64, LFD = 2, DW = 4, SAT = (1 << DW) - 1;

   logic          clk_i = 1'b0, rstn_i = 1'b0, clr_i = 1'b0;
   logic [7:0]    s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0, s_axis_tready;
   logic [1:0]    cfg_datasize_i = 2'd2;
   logic [31:0]   data_o;
   logic          data_valid_o, data_ready_i = 1'b0, data_last_o, frame_busy_o, drop_o;
   logic [1:0]    data_datasize_o;
   logic [6:0]    frame_len_o;
   logic [DW-1:0] drop_cnt_o;

   int          vectors = 0, miscompares = 0;
   int          exp_drops = 0, exp_pulses = 0, pulses = 0, rdy_mode = 0, lat;
   logic [63:0] exp_q[$];
   logic [7:0]  frm[256];

   udma_eth_frame_rx_buf #(.DEPTH(DEPTH), .LEN_FIFO_DEPTH(LFD), .DROP_CNT_W(DW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .cfg_datasize_i(cfg_datasize_i),
      .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
      .data_datasize_o(data_datasize_o), .data_last_o(data_last_o), .frame_len_o(frame_len_o),
      .frame_busy_o(frame_busy_o), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected beats of a good frame: {busy, last, datasize, len, data}
   function automatic void push_beats(input int len, input logic [1:0] cfg);
      int          n;
      logic [1:0]  dsz;
      logic [31:0] w;
      n   = cfg == 2'd0 ? 1 : cfg == 2'd1 ? 2 : 4;
      dsz = cfg == 2'd3 ? 2'd2 : cfg;
      for (int o = 0; o < len; o += n) begin
         w = '0;
         for (int k = 0; k < n && o + k < len; k++) w[8*k +: 8] = frm[o+k];
         exp_q.push_back({21'b0, 1'b1, 1'(o + n >= len), dsz, 7'(len), w});
      end
   endfunction

   initial forever begin
      @(posedge clk_i);
      #1 data_ready_i = rdy_mode == 2 ? ($urandom_range(0, 2) != 0) : (rdy_mode == 1);
   end

   always @(negedge clk_i) begin
      if (rstn_i && data_valid_o) begin
         if (exp_q.size() == 0) chk("spurious_beat", {32'b0, data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            chk("beat", {21'b0, frame_busy_o, data_last_o, data_datasize_o, frame_len_o, data_o}, exp_q[0]);
            if (data_ready_i) void'(exp_q.pop_front());
         end
      end
      if (rstn_i && drop_o) pulses++;
   end

   task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
      int g = 0;
      @(negedge clk_i);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      while (!s_axis_tready && g < 500) begin
         @(negedge clk_i);
         g++;
      end
      if (g >= 500) chk("tready_timeout", {63'b0, s_axis_tready}, 64'd1);
   endtask

   task automatic send_frame(input int len, input bit err, input bit keep);
      if (!keep) for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
      for (int i = 0; i < len; i++)
         send_byte(frm[i], i == len - 1, i == len - 1 ? err : 1'($urandom));
      if (!err && len <= DEPTH) push_beats(len, cfg_datasize_i);
      else begin
         exp_drops++;
         exp_pulses++;
      end
      @(negedge clk_i);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 1;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk_i);
      chk("idle_valid", {63'b0, data_valid_o}, 64'd0);
      chk("drop_cnt", 64'(drop_cnt_o), 64'(exp_drops > SAT ? SAT : exp_drops));
      chk("drop_pulses", 64'(pulses), 64'(exp_pulses));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_tready", {63'b0, s_axis_tready}, 64'd1);
      chk("rst_outs", {data_o, data_valid_o, data_last_o, frame_busy_o, drop_o, data_datasize_o, frame_len_o, drop_cnt_o}, 64'd0);
      rstn_i = 1'b1;
      // 5-byte frame, word beats, with first-beat latency
      rdy_mode = 1;
      cfg_datasize_i = 2'd2;
      frm[0] = 8'h11; frm[1] = 8'h22; frm[2] = 8'h33; frm[3] = 8'h44; frm[4] = 8'h55;
      for (int i = 0; i < 5; i++) send_byte(frm[i], i == 4, 1'b0);
      push_beats(5, 2'd2);
      lat = 0;
      do begin
         @(negedge clk_i);
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
         lat++;
      end while (!data_valid_o && lat < 10);
      chk("latency", 64'(lat), 64'd2);
      drain();
      // errored frame, then a good one
      send_frame(4, 1, 0);
      send_frame(6, 0, 0);
      drain();
      // oversized frame, exact-DEPTH frame, DEPTH+1 frame
      send_frame(70, 0, 0);
      send_frame(10, 0, 0);
      drain();
      send_frame(DEPTH, 0, 0);
      send_frame(DEPTH + 1, 0, 0);
      drain();
      // length FIFO fills while the reader is stalled
      rdy_mode = 0;
      repeat (3) send_frame(15, 0, 0);
      repeat (3) @(negedge clk_i);
      chk("tready_lf_full", {63'b0, s_axis_tready}, 64'd0);
      chk("busy_stalled", {63'b0, frame_busy_o}, 64'd1);
      drain();
      // byte then half-word beats on AA,BB,CC
      frm[0] = 8'hAA; frm[1] = 8'hBB; frm[2] = 8'hCC;
      cfg_datasize_i = 2'd0;
      send_frame(3, 0, 1);
      drain();
      cfg_datasize_i = 2'd1;
      send_frame(3, 0, 1);
      drain();
      cfg_datasize_i = 2'd3;
      send_frame(9, 0, 0);
      drain();
      // datasize change after the frame is popped must not affect it
      cfg_datasize_i = 2'd2;
      rdy_mode = 0;
      send_frame(9, 0, 0);
      repeat (3) @(negedge clk_i);
      cfg_datasize_i = 2'd0;
      drain();
      for (int p = 0; p < 3; p++) begin
         cfg_datasize_i = 2'($urandom_range(0, 3));
         rdy_mode = 2;
         repeat (25) send_frame($urandom_range(1, 20), $urandom_range(0, 4) == 0, 0);
         drain();
      end
      repeat (SAT + 2) send_frame(1, 1, 0);
      drain();
      // flush mid-frame: remainder discarded silently, counter cleared
      cfg_datasize_i = 2'd2;
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
      @(negedge clk_i);
      s_axis_tvalid = 1'b0;
      clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      exp_drops = 0;
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4, 1'b0);
      @(negedge clk_i);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("clr_drop_cnt", 64'(drop_cnt_o), 64'd0);
      chk("clr_valid", {63'b0, data_valid_o}, 64'd0);
      send_frame(7, 0, 0);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
